// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/complete channel between the fetch sequencer
// (master) and a stall/done style instruction memory (slave).
interface fetch_sequencer_if;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_done;
  logic [15:0] mem_data;

  modport master (output mem_req, output mem_addr, input mem_done, input mem_data);
  modport slave  (input mem_req, input mem_addr, output mem_done, output mem_data);
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage sequencer: one outstanding instruction-memory request, holds the
// instruction under decode stall, squashes in-flight fetches on redirect.
// Optional outstanding-request watchdog: define FETCH_TIMEOUT_EN.
module fetch_sequencer #(
  parameter logic [15:0] RESET_PC       = 16'h0000,
  parameter logic [15:0] NOP_INSTR      = 16'h0800,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.master mem,
  input  logic              redirect,
  input  logic [15:0]       redirect_PC,
  input  logic              stall,
  output logic [15:0]       instr,
  output logic              instr_valid,
  output logic [15:0]       curr_PC,
  output logic [15:0]       inc_PC,
  output logic              err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FULL, S_SQUASH} state_t;

  function automatic logic [15:0] pc_add2(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  state_t      state_q;
  logic [15:0] req_addr_q;
  logic [15:0] fetch_PC_q;
  logic [15:0] instr_q;
  logic [15:0] curr_PC_q;
  logic        instr_valid_q;
  logic        issue;

  // FULL issues the next fetch only when decode consumes the held instruction.
  assign issue        = (state_q == S_FULL) && !stall && !redirect;
  assign mem.mem_req  = (state_q == S_WAIT) || (state_q == S_SQUASH) || issue;
  assign mem.mem_addr = (state_q == S_FULL) ? fetch_PC_q : req_addr_q;

  assign instr        = instr_valid_q ? instr_q : NOP_INSTR;
  assign instr_valid  = instr_valid_q;
  assign curr_PC      = curr_PC_q;
  assign inc_PC       = pc_add2(curr_PC_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      req_addr_q    <= RESET_PC;
      fetch_PC_q    <= RESET_PC;
      instr_q       <= NOP_INSTR;
      curr_PC_q     <= RESET_PC;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_addr_q <= RESET_PC;
          state_q    <= S_WAIT;
        end
        S_WAIT: begin
          if (mem.mem_done) begin
            if (redirect) begin
              req_addr_q <= redirect_PC;
            end else begin
              instr_q       <= mem.mem_data;
              curr_PC_q     <= req_addr_q;
              fetch_PC_q    <= pc_add2(req_addr_q);
              instr_valid_q <= 1'b1;
              state_q       <= S_FULL;
            end
          end else if (redirect) begin
            // Old request must still complete; remember where to go afterwards.
            fetch_PC_q <= redirect_PC;
            state_q    <= S_SQUASH;
          end
        end
        S_FULL: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            req_addr_q    <= redirect_PC;
            state_q       <= S_WAIT;
          end else if (!stall) begin
            if (mem.mem_done) begin
              instr_q    <= mem.mem_data;
              curr_PC_q  <= fetch_PC_q;
              fetch_PC_q <= pc_add2(fetch_PC_q);
            end else begin
              req_addr_q    <= fetch_PC_q;
              instr_valid_q <= 1'b0;
              state_q       <= S_WAIT;
            end
          end
        end
        S_SQUASH: begin
          if (mem.mem_done) begin
            req_addr_q <= redirect ? redirect_PC : fetch_PC_q;
            state_q    <= S_WAIT;
          end else if (redirect) begin
            fetch_PC_q <= redirect_PC;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;
  logic [CNT_W-1:0] tmo_cnt_d;
  logic             err_q;
  logic             waiting;

  assign waiting = ((state_q == S_WAIT) || (state_q == S_SQUASH)) && !mem.mem_done;

  always_comb begin
    tmo_cnt_d = '0;
    if (waiting) begin
      tmo_cnt_d = (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES)) ? tmo_cnt_q : tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      if (tmo_cnt_d == CNT_W'(TIMEOUT_CYCLES)) err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  // No watchdog built; the limit parameter has no effect here.
  assign err = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed phases push expected
// instructions, a negedge monitor pops and compares each new instruction.
module tb_fetch_sequencer;

  localparam logic [15:0] KEY = 16'hC3A5;
  localparam logic [15:0] NOP = 16'h0800;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] redirect_PC = 16'h0000;
  logic [15:0] instr, curr_PC, inc_PC;
  logic        instr_valid, err;

  logic        z_redirect = 1'b0;
  logic        z_stall = 1'b0;
  logic [15:0] z_pc = 16'h0000;
  logic [15:0] instr2, curr_PC2, inc_PC2;
  logic        instr_valid2, err2;

  fetch_sequencer_if mif ();
  fetch_sequencer_if mif2 ();

  fetch_sequencer #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .mem(mif.master),
    .redirect(redirect), .redirect_PC(redirect_PC), .stall(stall),
    .instr(instr), .instr_valid(instr_valid), .curr_PC(curr_PC),
    .inc_PC(inc_PC), .err(err)
  );

  fetch_sequencer #(.RESET_PC(16'hFFFE)) dut2 (
    .clk(clk), .rst(rst), .mem(mif2.master),
    .redirect(z_redirect), .redirect_PC(z_pc), .stall(z_stall),
    .instr(instr2), .instr_valid(instr_valid2), .curr_PC(curr_PC2),
    .inc_PC(inc_PC2), .err(err2)
  );

  // Memory model: done in the lat-th cycle of a request, data = addr ^ KEY.
  int lat = 1;
  bit mem_hold = 1'b0;
  int cyc = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else if (!mif.mem_req || mif.mem_done) cyc <= 0;
    else cyc <= cyc + 1;
  end
  assign mif.mem_done  = mif.mem_req && !mem_hold && (cyc >= lat - 1);
  assign mif.mem_data  = mif.mem_addr ^ KEY;
  assign mif2.mem_done = mif2.mem_req;
  assign mif2.mem_data = mif2.mem_addr ^ KEY;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_q[$];

  function automatic void chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Monitor: a new instruction is presented when valid follows invalid or a consume.
  bit prev_v = 1'b0;
  bit prev_c = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_v = 1'b0;
      prev_c = 1'b0;
    end else begin
      if (instr_valid && (!prev_v || prev_c)) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_instr: got pc %h instr %h expected none", curr_PC, instr);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          chk("sb_curr_PC", curr_PC, e);
          chk("sb_instr", instr, e ^ KEY);
          chk("sb_inc_PC", inc_PC, e + 16'd2);
        end
      end
      prev_v = instr_valid;
      prev_c = instr_valid && !stall && !redirect;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mem_req_async", {15'd0, mif.mem_req}, 16'd0);
    chk("sb_queue_drained", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    redirect = 1'b0;
    stall = 1'b0;
    mem_hold = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_pc(input logic [15:0] pc, input string nm);
    int n;
    n = 0;
    while (!(instr_valid && curr_PC == pc) && n < 200) begin
      tick();
      n++;
    end
    n_checks++;
    if (n >= 200) begin
      n_fail++;
      $display("FAIL %s: pc %h not presented, curr_PC %h after %0d cycles", nm, pc, curr_PC, n);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) tick();
    chk("rst_mem_req", {15'd0, mif.mem_req}, 16'd0);
    chk("rst_mem_addr", mif.mem_addr, 16'h0000);
    chk("rst_instr", instr, NOP);
    chk("rst_instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_curr_PC", curr_PC, 16'h0000);
    chk("rst_inc_PC", inc_PC, 16'h0002);
    chk("rst_err", {15'd0, err}, 16'd0);

    // Zero-wait memory: one instruction per cycle; dut2 wraps from FFFE.
    lat = 1;
    for (int i = 0; i < 8; i++) exp_q.push_back(16'(2 * i));
    rst = 1'b1;
    tick();
    chk("zw_req_e1", {15'd0, mif.mem_req}, 16'd1);
    chk("zw_addr_e1", mif.mem_addr, 16'h0000);
    chk("wrap_addr_e1", mif2.mem_addr, 16'hFFFE);
    tick();
    chk("zw_addr_e2", mif.mem_addr, 16'h0002);
    chk("zw_valid_e2", {15'd0, instr_valid}, 16'd1);
    chk("wrap_addr_e2", mif2.mem_addr, 16'h0000);
    chk("wrap_curr_PC", curr_PC2, 16'hFFFE);
    chk("wrap_inc_PC", inc_PC2, 16'h0000);
    chk("wrap_instr", instr2, 16'h3C5B);
    tick();
    chk("zw_addr_e3", mif.mem_addr, 16'h0004);
    chk("zw_valid_e3", {15'd0, instr_valid}, 16'd1);
    repeat (6) tick();
    do_reset();

    // 3-cycle memory, stall held 4 cycles while FULL at 0x0010.
    lat = 3;
    for (int i = 0; i < 10; i++) exp_q.push_back(16'(2 * i));
    rst = 1'b1;
    wait_pc(16'h0010, "reach_0010");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall_instr", instr, 16'h0010 ^ KEY);
      chk("stall_curr_PC", curr_PC, 16'h0010);
      chk("stall_mem_req", {15'd0, mif.mem_req}, 16'd0);
      chk("stall_valid", {15'd0, instr_valid}, 16'd1);
    end
    stall = 1'b0;
    #1;
    chk("unstall_req", {15'd0, mif.mem_req}, 16'd1);
    chk("unstall_addr", mif.mem_addr, 16'h0012);
    wait_pc(16'h0012, "reach_0012");
    do_reset();

    // Redirect during request to 0x0020 -> squash, then redirect+stall in FULL.
    lat = 3;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0100);
    exp_q.push_back(16'h0200);
    rst = 1'b1;
    wait_pc(16'h0000, "reach_0000");
    redirect = 1'b1;
    redirect_PC = 16'h0020;
    tick();
    chk("redir_req_0020", {15'd0, mif.mem_req}, 16'd1);
    chk("redir_addr_0020", mif.mem_addr, 16'h0020);
    redirect_PC = 16'h0100;
    tick();
    redirect = 1'b0;
    chk("squash_addr_held", mif.mem_addr, 16'h0020);
    chk("squash_valid", {15'd0, instr_valid}, 16'd0);
    n = 0;
    while (mif.mem_addr == 16'h0020 && n < 20) begin
      tick();
      n++;
    end
    chk("squash_next_addr", mif.mem_addr, 16'h0100);
    wait_pc(16'h0100, "reach_0100");
    redirect = 1'b1;
    stall = 1'b1;
    redirect_PC = 16'h0200;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    chk("rs_valid_drop", {15'd0, instr_valid}, 16'd0);
    chk("rs_instr_nop", instr, NOP);
    chk("rs_req", {15'd0, mif.mem_req}, 16'd1);
    chk("rs_addr", mif.mem_addr, 16'h0200);
    wait_pc(16'h0200, "reach_0200");
    do_reset();

    // Memory withheld: watchdog behaviour (err stays 0 without the feature).
    lat = 3;
    mem_hold = 1'b1;
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0002);
    rst = 1'b1;
    repeat (8) tick();
    chk("tmo_err_before", {15'd0, err}, 16'd0);
    tick();
`ifdef FETCH_TIMEOUT_EN
    chk("tmo_err_set", {15'd0, err}, 16'd1);
`else
    chk("tmo_err_off", {15'd0, err}, 16'd0);
`endif
    mem_hold = 1'b0;
    repeat (6) tick();
`ifdef FETCH_TIMEOUT_EN
    chk("tmo_err_sticky", {15'd0, err}, 16'd1);
`else
    chk("tmo_err_off_after", {15'd0, err}, 16'd0);
`endif
    do_reset();
    chk("tmo_err_cleared", {15'd0, err}, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
